// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite write join front end.
package axil_pkg;

  localparam int unsigned PROT_W = 3;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } wj_state_e;

  // Decode failure outranks the protection failure.
  function automatic logic [RESP_W-1:0] resp_sel(input logic dec_fail, input logic prot_fail);
    if (dec_fail)       return RESP_DECERR;
    else if (prot_fail) return RESP_SLVERR;
    else                return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_chan_buf.sv
// One-entry holding register for a valid/ready channel; ready while empty.
module axil_chan_buf
  import axil_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_clr,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  // Capture the payload on handshake; the clear empties the entry.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

  // Ready is withheld while reset is applied, then follows the empty flag.
  assign o_ready = ~r_full & ~ARESETn;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/axil_write_join.sv
// AXI4-Lite write front end: joins AW and W, issues one register write, returns B.
// Optional build macro: AXIL_WJOIN_PROT_CHECK_EN (non-secure writes get SLVERR).
module axil_write_join
  import axil_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0000_1000)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [PROT_W-1:0]   AWPROT,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [RESP_W-1:0]   BRESP,
  output logic                reg_wen,
  output logic [ADDR_W-1:0]   reg_waddr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned AW_PL_W = ADDR_W + PROT_W;
  localparam int unsigned W_PL_W  = DATA_W + STRB_W;

  wj_state_e r_state;
  wj_state_e w_next_state;

  logic                r_bvalid;
  logic [RESP_W-1:0]   r_bresp;
  logic                r_reg_wen;
  logic [ADDR_W-1:0]   r_reg_waddr;
  logic [DATA_W-1:0]   r_reg_wdata;
  logic [STRB_W-1:0]   r_reg_wstrb;

  logic                w_aw_full;
  logic                w_w_full;
  logic [AW_PL_W-1:0]  w_aw_pl;
  logic [W_PL_W-1:0]   w_w_pl;
  logic [ADDR_W-1:0]   w_aw_addr;
  logic [PROT_W-1:0]   w_aw_prot;
  logic [DATA_W-1:0]   w_w_data;
  logic [STRB_W-1:0]   w_w_strb;
  logic                w_clr;
  logic                w_dec_fail;
  logic                w_prot_fail;
  logic [RESP_W-1:0]   w_resp;
  logic                w_wen_ok;
  logic                w_unused;

  assign w_clr = r_bvalid & BREADY;

  axil_chan_buf #(.W(AW_PL_W)) u_aw_buf (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_valid (AWVALID),
    .i_data  ({AWADDR, AWPROT}),
    .i_clr   (w_clr),
    .o_ready (AWREADY),
    .o_full  (w_aw_full),
    .o_data  (w_aw_pl)
  );

  axil_chan_buf #(.W(W_PL_W)) u_w_buf (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_valid (WVALID),
    .i_data  ({WDATA, WSTRB}),
    .i_clr   (w_clr),
    .o_ready (WREADY),
    .o_full  (w_w_full),
    .o_data  (w_w_pl)
  );

  assign {w_aw_addr, w_aw_prot} = w_aw_pl;
  assign {w_w_data, w_w_strb}   = w_w_pl;

  // Response decode from the held entries; stable for the whole transaction.
  assign w_dec_fail = (w_aw_addr >= ADDR_LIMIT);
`ifdef AXIL_WJOIN_PROT_CHECK_EN
  assign w_prot_fail = w_aw_prot[1];
  assign w_unused    = ^{w_aw_prot[2], w_aw_prot[0]};
`else
  assign w_prot_fail = 1'b0;
  assign w_unused    = ^w_aw_prot;
`endif
  assign w_resp   = resp_sel(w_dec_fail, w_prot_fail);
  assign w_wen_ok = (w_resp == RESP_OKAY) && (|w_w_strb);

  // State register.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic: join, one write cycle, then hold the response.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_aw_full && w_w_full) w_next_state = WRITE;
      WRITE:   w_next_state = RESP;
      RESP:    if (BREADY) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered outputs, loaded on entry to the state that presents them.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      r_reg_wen   <= 1'b0;
      r_reg_waddr <= '0;
      r_reg_wdata <= '0;
      r_reg_wstrb <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
    end else begin
      if (w_next_state == WRITE) begin
        r_reg_wen   <= w_wen_ok;
        r_reg_waddr <= {w_aw_addr[ADDR_W-1:2], 2'b00};
        r_reg_wdata <= w_w_data;
        r_reg_wstrb <= w_w_strb;
      end else begin
        r_reg_wen   <= 1'b0;
        r_reg_waddr <= '0;
        r_reg_wdata <= '0;
        r_reg_wstrb <= '0;
      end
      r_bvalid <= (w_next_state == RESP);
      r_bresp  <= (w_next_state == RESP) ? w_resp : RESP_OKAY;
    end
  end

  assign BVALID    = r_bvalid;
  assign BRESP     = r_bresp;
  assign reg_wen   = r_reg_wen;
  assign reg_waddr = r_reg_waddr;
  assign reg_wdata = r_reg_wdata;
  assign reg_wstrb = r_reg_wstrb;

endmodule

// File: tb/tb_axil_write_join.sv
// Self-checking bench for axil_write_join: directed cases plus random transactions.
module tb_axil_write_join;

  logic        ACLK    = 1'b0;
  logic        ARESETn = 1'b1;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR  = '0;
  logic [2:0]  AWPROT  = '0;
  logic        WVALID  = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA   = '0;
  logic [3:0]  WSTRB   = '0;
  logic        BVALID;
  logic        BREADY  = 1'b0;
  logic [1:0]  BRESP;
  logic        reg_wen;
  logic [31:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;

  int checks = 0;
  int errors = 0;

  axil_write_join dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .AWADDR    (AWADDR),
    .AWPROT    (AWPROT),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .BRESP     (BRESP),
    .reg_wen   (reg_wen),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference response: out-of-range beats everything, then optional protection check.
  function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] prot);
    logic [1:0] r;
    r = 2'b00;
`ifdef AXIL_WJOIN_PROT_CHECK_EN
    if (prot[1]) r = 2'b10;
`else
    if (prot[1] && 1'b0) r = 2'b10;
`endif
    if (addr >= 32'h0000_1000) r = 2'b11;
    return r;
  endfunction

  // One transaction with per-channel start delays; timeline expectations are
  // counted in edges from the moment both channels have been accepted.
  task automatic run_txn(input logic [31:0] addr, input logic [2:0] prot,
                         input logic [31:0] data, input logic [3:0] strb,
                         input int aw_dly, input int w_dly, input int b_dly);
    bit         aw_acc, w_acc, b_done, aw_hs, w_hs, b_hs, wen_ok;
    int         since;
    logic [1:0] exp_resp;
    logic [31:0] exp_waddr;
    exp_resp  = model_resp(addr, prot);
    wen_ok    = (exp_resp == 2'b00) && (strb != 4'd0);
    exp_waddr = {addr[31:2], 2'b00};
    aw_acc = 0; w_acc = 0; b_done = 0; since = -1;
    for (int cyc = 0; cyc < 100 && !b_done; cyc++) begin
      @(negedge ACLK);
      check("awready", 32'(AWREADY), 32'(!aw_acc));
      check("wready",  32'(WREADY),  32'(!w_acc));
      check("bvalid",  32'(BVALID),  32'(since >= 2));
      if (since >= 2) check("bresp", 32'(BRESP), 32'(exp_resp));
      check("reg_wen", 32'(reg_wen), 32'((since == 1) && wen_ok));
      check("reg_waddr", reg_waddr, (since == 1) ? exp_waddr : 32'h0);
      check("reg_wdata", reg_wdata, (since == 1) ? data : 32'h0);
      check("reg_wstrb", 32'(reg_wstrb), (since == 1) ? 32'(strb) : 32'h0);
      AWVALID = !aw_acc && (cyc >= aw_dly);
      WVALID  = !w_acc  && (cyc >= w_dly);
      AWADDR  = aw_acc ? $urandom : addr;
      AWPROT  = aw_acc ? 3'($urandom) : prot;
      WDATA   = w_acc ? $urandom : data;
      WSTRB   = w_acc ? 4'($urandom) : strb;
      BREADY  = (cyc >= b_dly);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      @(posedge ACLK);
      if (aw_hs) aw_acc = 1;
      if (w_hs)  w_acc = 1;
      if (b_hs)  b_done = 1;
      if (since >= 0) since++;
      else if (aw_acc && w_acc) since = 0;
    end
    check("b_done", 32'(b_done), 32'd1);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; BREADY = 0;
    check("post_awready", 32'(AWREADY), 32'd1);
    check("post_wready",  32'(WREADY),  32'd1);
    check("post_bvalid",  32'(BVALID),  32'd0);
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_bvalid",  32'(BVALID),  32'd0);
    check("rst_reg_wen", 32'(reg_wen), 32'd0);
    ARESETn = 1'b0;
    #1;
    check("rel_awready", 32'(AWREADY), 32'd1);
    check("rel_wready",  32'(WREADY),  32'd1);
    check("rel_bresp",   32'(BRESP),   32'd0);

    // Directed cases
    run_txn(32'h0000_0010, 3'b000, 32'hDEAD_BEEF, 4'hF,   0, 0, 0);
    run_txn(32'h0000_0024, 3'b000, 32'h1234_5678, 4'b0011, 3, 0, 0);
    run_txn(32'h0000_2000, 3'b000, 32'hCAFE_F00D, 4'hF,   0, 0, 0);
    run_txn(32'h0000_0100, 3'b000, 32'hA5A5_5A5A, 4'hF,   0, 1, 14);
    run_txn(32'h0000_0200, 3'b000, 32'h0BAD_0BAD, 4'h0,   0, 0, 0);
    run_txn(32'h0000_0300, 3'b010, 32'h1111_2222, 4'hF,   1, 0, 2);
    run_txn(32'h0000_0FFC, 3'b000, 32'h3333_4444, 4'b1000, 0, 0, 0);
    run_txn(32'h0000_1000, 3'b000, 32'h5555_6666, 4'hF,   0, 0, 0);
    run_txn(32'h0000_0013, 3'b000, 32'h7777_8888, 4'b0100, 0, 2, 0);

    // Reset pulsed while the response is pending
    @(negedge ACLK);
    AWADDR = 32'h40; AWPROT = 3'b000; WDATA = 32'h9999_AAAA; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1; BREADY = 0;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (BVALID) seen = 1;
      else @(negedge ACLK);
    end
    check("rst_mid_bvalid_seen", 32'(seen), 32'd1);
    #2 ARESETn = 1'b1;
    #1;
    check("rst_mid_bvalid", 32'(BVALID), 32'd0);
    check("rst_mid_reg_wen", 32'(reg_wen), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    check("rst_mid_awready", 32'(AWREADY), 32'd1);
    check("rst_mid_wready",  32'(WREADY),  32'd1);
    run_txn(32'h0000_0044, 3'b000, 32'hBBBB_CCCC, 4'b0110, 0, 0, 0);

    // Random transactions
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = $urandom_range(32'h1FFF, 0);
      d = $urandom;
      s = ($urandom_range(3, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      run_txn(a, 3'($urandom), d, s, int'($urandom_range(4, 0)),
              int'($urandom_range(4, 0)), int'($urandom_range(6, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_write_join.md
Name: axil_write_join

Overview:
- AXI4-Lite slave-side write front end.
- Accepts the write address (AW) and write data (W) channels independently and holds one entry of each.
- Once both are held, issues a single-cycle register-file write, then returns the write response (B).
- Sits between the interconnect and the register file, directly downstream of the AW/W channel sources; one outstanding write at a time.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits (32 only); WSTRB width is DATA_W/8.
- ADDR_LIMIT, 32'h0000_1000, byte addresses >= this value decode-fail.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-high
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- AWADDR  in  ADDR_W  write byte address
- AWPROT  in  3  protection attributes
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte strobes
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- BRESP  out  2  response code
- reg_wen  out  1  register write pulse
- reg_waddr  out  ADDR_W  word-aligned address, bits [1:0] forced 0
- reg_wdata  out  DATA_W  write data
- reg_wstrb  out  DATA_W/8  byte enables

Behaviour:
- Reset: all buffers empty, FSM IDLE, outputs 0, except AWREADY=1 and WREADY=1 once ARESETn deasserts. Reset asserted mid-transaction clears everything immediately (BVALID and reg_wen drop asynchronously); the transaction is lost.
- AW buffer: AWREADY = !aw_full.
  - On AWVALID&&AWREADY at an edge: latch AWADDR/AWPROT, set aw_full.
- W buffer: WREADY = !w_full.
  - On WVALID&&WREADY at an edge: latch WDATA/WSTRB, set w_full.
- AW and W may arrive in either order or in the same cycle. Neither channel waits for the other to become ready.
- FSM states:
  - IDLE: when aw_full&&w_full, go to WRITE next edge.
  - WRITE: exactly one cycle.
    - Outputs reg_waddr/reg_wdata/reg_wstrb from the buffers.
    - reg_wen=1 only if the address is in range and WSTRB!=0.
    - Computes and registers BRESP.
    - Go to RESP.
  - RESP: BVALID=1, BRESP held stable until BREADY. On BVALID&&BREADY: clear aw_full and w_full, go to IDLE.
- BRESP codes:
  - 2'b00 OKAY: normal completion, including WSTRB==0 (no write performed).
  - 2'b11 DECERR: AWADDR >= ADDR_LIMIT; reg_wen suppressed.
  - 2'b10 SLVERR: see Optional Feature.
- Latency: both channels handshaked at edge N -> reg_wen high in cycle N+1 -> BVALID high in cycle N+2. With BREADY already high, AWREADY/WREADY return at N+3.
- Backpressure: BREADY low holds RESP indefinitely. AWREADY/WREADY stay low while their buffer is full.
- reg_* outputs are 0 outside WRITE.
- Unaligned AWADDR: bits [1:0] are ignored (forced 0 on reg_waddr); no error.

Optional Feature:
- Macro: AXIL_WJOIN_PROT_CHECK_EN.
- Defined: a write with AWPROT[1]==1 (non-secure) gets BRESP=2'b10 SLVERR and no reg_wen. DECERR takes priority over SLVERR.
- Undefined: AWPROT is latched but ignored; SLVERR is never produced.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - FSM state typedef {IDLE, WRITE, RESP}.
- Sub-module axil_chan_buf: a one-entry holding register with full flag, parameterised payload width, ready=!full, and a clear input. It is instantiated twice (AW payload ADDR_W+3, W payload DATA_W+DATA_W/8).

Test Plan:
- AW 0x0000_0010 and W 0xDEADBEEF/4'hF in the same cycle, BREADY=1 -> reg_wen one cycle with addr 0x10, data 0xDEADBEEF; BVALID two cycles after handshake, BRESP=00.
- W first (0x12345678, 4'b0011), AW 0x24 three cycles later -> WREADY=0 while waiting; reg_wstrb=4'b0011, reg_waddr=0x24, BRESP=00.
- AWADDR 0x0000_2000 -> no reg_wen; BRESP=11.
- BREADY held low 10 cycles -> BVALID/BRESP stable; AWREADY=WREADY=0 throughout; a second AW is accepted only after the B handshake.
- WSTRB=0 -> no reg_wen, BRESP=00. With AXIL_WJOIN_PROT_CHECK_EN, AWPROT=3'b010 -> BRESP=10, no reg_wen.
- ARESETn pulsed during RESP -> BVALID=0 immediately; after release AWREADY=WREADY=1 and the FSM is in IDLE.
